alu_pipe: RTL and testbench

Parametrised, handshaked ALU for the datapath that replaces the purely combinational 32-bit ALU. It takes operands and an operation code through a valid/ready input port and returns a registered Result plus NZCV flags through a valid/ready output port. Single-cycle operations run at full throughput. A multiply runs iteratively over WIDTH cycles. It sits between the register-read stage and writeback, and either side may stall it.

---
 rtl/alu_pipe.sv | 160 ++++++++++++++++
 tb/tb_alu_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply,
// registered Result/NZCV flags behind a valid/ready output port.
`timescale 1ns/1ps
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST_ITER = SW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t           state_r;
    logic [SW-1:0]    cnt_r;
    logic [WIDTH-1:0] mul_a_r;
    logic [WIDTH-1:0] mul_b_r;
    logic [WIDTH-1:0] acc_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [3:0]       flags_r;

    logic             accept_s;
    logic             is_mul_s;
    logic             mul_done_s;
    logic [SW-1:0]    shamt_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH:0]   lsl_s;
    logic [WIDTH:0]   lsr_s;
    logic [WIDTH-1:0] mul_sum_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s;
    logic             alu_v_s;

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        return {r[WIDTH-1], (r == {WIDTH{1'b0}}), c, v};
    endfunction

    assign in_ready   = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign accept_s   = in_valid && in_ready;
    assign is_mul_s   = (ALUControl == 3'b111);
    assign mul_done_s = (state_r == ST_MUL) && (cnt_r == LAST_ITER);
    assign shamt_s    = b[SW-1:0];
    assign add_s      = {1'b0, a} + {1'b0, b};
    assign sub_s      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    // The extra bit catches the last bit shifted out; it is zero for a zero shift.
    assign lsl_s      = {1'b0, a} << shamt_s;
    assign lsr_s      = {a, 1'b0} >> shamt_s;
    assign mul_sum_s  = acc_r + (mul_b_r[0] ? mul_a_r : {WIDTH{1'b0}});

    assign out_valid  = out_valid_r;
    assign Result     = result_r;
    assign ALUFlags   = flags_r;

    // Single-cycle operation result, carry and overflow.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (ALUControl)
            3'b000: begin
                alu_res_s = add_s[WIDTH-1:0];
                alu_c_s   = add_s[WIDTH];
                alu_v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                alu_res_s = sub_s[WIDTH-1:0];
                alu_c_s   = sub_s[WIDTH];
                alu_v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010: alu_res_s = a & b;
            3'b011: alu_res_s = a | b;
            3'b100: alu_res_s = a ^ b;
            3'b101: begin
                alu_res_s = lsl_s[WIDTH-1:0];
                alu_c_s   = lsl_s[WIDTH];
            end
            3'b110: begin
                alu_res_s = lsr_s[WIDTH:1];
                alu_c_s   = lsr_s[0];
            end
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Sequencer and shift-add multiplier state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {SW{1'b0}};
            mul_a_r <= {WIDTH{1'b0}};
            mul_b_r <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && is_mul_s) begin
                        state_r <= ST_MUL;
                        cnt_r   <= {SW{1'b0}};
                        mul_a_r <= a;
                        mul_b_r <= b;
                        acc_r   <= {WIDTH{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc_r   <= mul_sum_s;
                    mul_a_r <= mul_a_r << 1;
                    mul_b_r <= mul_b_r >> 1;
                    if (cnt_r == LAST_ITER) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {SW{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r + {{(SW-1){1'b0}}, 1'b1};
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Output register: a new load wins over a drain on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            flags_r     <= 4'b0000;
        end else if (accept_s && !is_mul_s) begin
            out_valid_r <= 1'b1;
            result_r    <= alu_res_s;
            flags_r     <= pack_flags(alu_res_s, alu_c_s, alu_v_s);
        end else if (mul_done_s) begin
            out_valid_r <= 1'b1;
            result_r    <= mul_sum_s;
            flags_r     <= pack_flags(mul_sum_s, 1'b0, 1'b0);
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed, table-driven bench for alu_pipe (WIDTH=32) with hand-computed expectations.
`timescale 1ns/1ps
module tb_alu_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   ALUControl = 3'b000;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] Result;
    logic [3:0]   ALUFlags;

    int n_cmp = 0;
    int n_err = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALUControl(ALUControl), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .ALUFlags(ALUFlags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input logic [31:0] ma, input logic [31:0] mb,
                           input logic [31:0] eres, input logic [3:0] eflg);
        int n;
        int lows;
        check("mul_in_ready_before", {31'd0, in_ready}, 32'd1);
        a = ma; b = mb; ALUControl = 3'b111; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        lows = 0;
        while (out_valid !== 1'b1 && n < W + 10) begin
            if (in_ready === 1'b0) lows++;
            a = $urandom; b = $urandom; ALUControl = 3'($urandom_range(0, 7));
            tick();
            n++;
        end
        check("mul_latency", n, W);
        check("mul_in_ready_low_cycles", lows, W);
        check("mul_result", Result, eres);
        check("mul_flags", {28'd0, ALUFlags}, {28'd0, eflg});
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
        vecs[1]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
        vecs[2]  = '{3'b001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000};
        vecs[3]  = '{3'b101, 32'h80000001, 32'h00000001, 32'h00000002, 4'b0010};
        vecs[4]  = '{3'b110, 32'h00000003, 32'h00000001, 32'h00000001, 4'b0010};
        vecs[5]  = '{3'b101, 32'h12345678, 32'h00000000, 32'h12345678, 4'b0000};
        vecs[6]  = '{3'b101, 32'h92345678, 32'h00000020, 32'h92345678, 4'b1000};
        vecs[7]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
        vecs[8]  = '{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
        vecs[9]  = '{3'b010, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 4'b0000};
        vecs[10] = '{3'b010, 32'h0000000F, 32'h000000F0, 32'h00000000, 4'b0100};
        vecs[11] = '{3'b011, 32'h000000F0, 32'h0000000F, 32'h000000FF, 4'b0000};
        vecs[12] = '{3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 4'b1000};
        vecs[13] = '{3'b101, 32'hF0000000, 32'h00000004, 32'h00000000, 4'b0110};
        vecs[14] = '{3'b110, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000};
        vecs[15] = '{3'b110, 32'h40000000, 32'h0000001F, 32'h00000000, 4'b0110};

        // Reset state
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_flags", {28'd0, ALUFlags}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back single-cycle ops at full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            a = vecs[i].va; b = vecs[i].vb; ALUControl = vecs[i].op; in_valid = 1'b1;
            tick();
            check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_result", i), Result, vecs[i].res);
            check($sformatf("vec%0d_flags", i), {28'd0, ALUFlags}, {28'd0, vecs[i].flg});
        end
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);

        // Multiply
        run_mul(32'h00010000, 32'h00010000, 32'h00000000, 4'b0100);
        tick();
        run_mul(32'h00000007, 32'h00000006, 32'd42, 4'b0000);
        tick();
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000);
        tick();
        run_mul(32'h00010000, 32'h00008000, 32'h80000000, 4'b1000);
        tick();
        check("mul_drained", {31'd0, out_valid}, 32'd0);

        // Back-pressure: result held, input blocked, then simultaneous drain + accept
        out_ready = 1'b0;
        a = 32'hF0; b = 32'h0F; ALUControl = 3'b011; in_valid = 1'b1;
        tick();
        a = 32'h0000FF00; b = 32'h00000FF0; ALUControl = 3'b010;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d_result", i), Result, 32'h000000FF);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_new_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_new_result", Result, 32'h00000F00);
        check("bp_new_flags", {28'd0, ALUFlags}, 32'd0);
        tick();
        check("bp_final_drain", {31'd0, out_valid}, 32'd0);

        // Reset ten cycles into a multiply
        a = 32'd3; b = 32'd5; ALUControl = 3'b111; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("pre_rst_result_nonzero", {31'd0, (Result != 32'd0)}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", Result, 32'd0);
        check("midrst_flags", {28'd0, ALUFlags}, 32'd0);
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        begin
            int stale;
            stale = 0;
            for (int i = 0; i < W + 8; i++) begin
                tick();
                if (out_valid !== 1'b0) stale++;
            end
            check("postrst_no_stale", stale, 0);
        end
        a = 32'd1; b = 32'd2; ALUControl = 3'b000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("postrst_add_valid", {31'd0, out_valid}, 32'd1);
        check("postrst_add_result", Result, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
